// File: rtl/hazard_pkg.sv
// Shared types for the hazard / forwarding control slice.
// FSM encoding and the register-file select value.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  localparam int unsigned FWD_RF = 0;

endpackage

// File: rtl/fwd_select.sv
// Priority forwarding match for one EX source operand.
// The nearest write-enabled stage holding a non-x0 match wins.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int SELW    = 2
) (
  input  logic [4:0]           rs,
  input  logic [5*NUM_FWD-1:0] stage_rd,
  input  logic [NUM_FWD-1:0]   stage_we,
  output logic [SELW-1:0]      sel
);

  // Walk from the farthest stage down so the nearest match is written last.
  always_comb begin
    sel = SELW'(FWD_RF);
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (stage_we[k] &&
          stage_rd[5*k +: 5] != 5'd0 &&
          stage_rd[5*k +: 5] == rs) begin
        sel = SELW'(k + 1);
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Pipeline hazard control: operand forwarding, load-use stall,
// data-memory wait freeze with timeout fault and a stall counter.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter  int NUM_SRC = 2,
  parameter  int NUM_FWD = 2,
  parameter  int TIMEOUT = 16,
  localparam int SELW    = $clog2(NUM_FWD + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [5*NUM_SRC-1:0]    ex_rs,
  input  logic [5*NUM_FWD-1:0]    stage_rd,
  input  logic [NUM_FWD-1:0]      stage_we,
  input  logic [5*NUM_SRC-1:0]    id_rs,
  input  logic [NUM_SRC-1:0]      id_rs_used,
  input  logic                    ex_is_load,
  input  logic [4:0]              ex_rd,
  input  logic                    mem_req,
  input  logic                    dmem_ack,
  output logic [SELW*NUM_SRC-1:0] fwd_sel,
  output logic                    stall_if,
  output logic                    stall_id,
  output logic                    bubble_ex,
  output logic                    freeze,
  output logic                    bus_fault,
  output logic [15:0]             stall_count
);

  state_t state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic [SELW*NUM_SRC-1:0] sel_raw;
  logic rd_hit, load_use, mem_stall, frz;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_select #(
      .NUM_FWD(NUM_FWD),
      .SELW   (SELW)
    ) u_sel (
      .rs      (ex_rs[5*i +: 5]),
      .stage_rd(stage_rd),
      .stage_we(stage_we),
      .sel     (sel_raw[SELW*i +: SELW])
    );
  end

  always_comb begin
    rd_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_rs_used[i] && id_rs[5*i +: 5] == ex_rd) rd_hit = 1'b1;
    end
  end

  assign load_use  = ex_is_load && ex_rd != 5'd0 && rd_hit;
  assign mem_stall = mem_req && !dmem_ack;

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    frz       = 1'b0;
    unique case (state)
      RUN: begin
        frz = mem_stall;
        if (mem_stall) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = 8'd1;
        end
      end
      MEM_WAIT: begin
        frz = 1'b1;
        // A late ack beats the timeout compare.
        if (dmem_ack) begin
          state_nxt = RUN;
          wait_nxt  = 8'd0;
        end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
          state_nxt = FAULT;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      FAULT: frz = 1'b1;
      default: state_nxt = RUN;
    endcase
  end

  assign freeze    = rst_n && frz;
  assign stall_if  = rst_n && (frz || load_use);
  assign stall_id  = stall_if;
  assign bubble_ex = rst_n && !frz && load_use;
  assign bus_fault = rst_n && state == FAULT;
  assign fwd_sel   = rst_n ? sel_raw : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      stall_count <= 16'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (stall_if && stall_count != 16'hFFFF) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl against a cycle-level
// behavioural model of forwarding, stalls, memory wait and timeout.
module tb_hazard_fwd_ctrl;

  localparam int NS = 2;
  localparam int NF = 2;
  localparam int SW = 2;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [5*NS-1:0] ex_rs;
  logic [5*NF-1:0] stage_rd;
  logic [NF-1:0] stage_we;
  logic [5*NS-1:0] id_rs;
  logic [NS-1:0] id_rs_used;
  logic          ex_is_load;
  logic [4:0]    ex_rd;
  logic          mem_req;
  logic          dmem_ack;
  logic [SW*NS-1:0] fwd_sel;
  logic          stall_if, stall_id, bubble_ex, freeze, bus_fault;
  logic [15:0]   stall_count;

  int n_vec = 0;
  int n_err = 0;

  int m_wait  = 0;
  bit m_fault = 1'b0;
  int m_cnt   = 0;

  hazard_fwd_ctrl #(
    .NUM_SRC(NS),
    .NUM_FWD(NF),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_rs      (ex_rs),
    .stage_rd   (stage_rd),
    .stage_we   (stage_we),
    .id_rs      (id_rs),
    .id_rs_used (id_rs_used),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .mem_req    (mem_req),
    .dmem_ack   (dmem_ack),
    .fwd_sel    (fwd_sel),
    .stall_if   (stall_if),
    .stall_id   (stall_id),
    .bubble_ex  (bubble_ex),
    .freeze     (freeze),
    .bus_fault  (bus_fault),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  wire [24:0] dut_out = {fwd_sel, stall_if, stall_id, bubble_ex,
                         freeze, bus_fault, stall_count};

  // Expected {fwd_sel, stall_if, stall_id, bubble_ex, freeze, bus_fault, count}
  function automatic logic [24:0] model_out();
    logic [SW*NS-1:0] fs;
    bit haz, fr, sif;
    fs  = '0;
    haz = 1'b0;
    for (int s = 0; s < NS; s++) begin
      int hit;
      hit = 0;
      for (int k = 0; k < NF; k++) begin
        if (hit == 0 && stage_we[k] && stage_rd[5*k +: 5] != 0 &&
            stage_rd[5*k +: 5] == ex_rs[5*s +: 5]) hit = k + 1;
      end
      fs[SW*s +: SW] = SW'(hit);
      if (ex_is_load && ex_rd != 0 && id_rs_used[s] &&
          id_rs[5*s +: 5] == ex_rd) haz = 1'b1;
    end
    fr  = m_fault || m_wait > 0 || (mem_req && !dmem_ack);
    sif = fr || haz;
    if (!rst_n) return {9'd0, 16'(m_cnt)};
    return {fs, sif, sif, !fr && haz, fr, m_fault, 16'(m_cnt)};
  endfunction

  task automatic tick();
    logic [24:0] e;
    e = model_out();
    @(posedge clk);
    if (!rst_n) begin
      m_wait = 0; m_fault = 1'b0; m_cnt = 0;
    end else begin
      if (e[20] && m_cnt < 65535) m_cnt++;
      if (!m_fault) begin
        if (m_wait > 0) begin
          if (dmem_ack) m_wait = 0;
          else if (m_wait == TO - 1) begin m_fault = 1'b1; m_wait = 0; end
          else m_wait++;
        end else if (mem_req && !dmem_ack) m_wait = 1;
      end
    end
    #1;
  endtask

  task automatic set_idle();
    ex_rs = '0; stage_rd = '0; stage_we = '0;
    id_rs = '0; id_rs_used = '0; ex_is_load = 1'b0;
    ex_rd = '0; mem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ex_rs = 10'($urandom); stage_rd = 10'($urandom); stage_we = 2'b11;
    id_rs = 10'($urandom); id_rs_used = 2'b11; ex_is_load = 1'b1;
    ex_rd = id_rs[4:0] | 5'd1; id_rs[4:0] = ex_rd;
    mem_req = 1'b1; dmem_ack = 1'b0;
    @(negedge clk); tick(); @(negedge clk);
    n_vec++;
    if (dut_out !== 25'd0) begin
      n_err++; $display("FAIL reset_outputs got=%h want=0", dut_out);
    end
    rst_n = 1'b1;
    set_idle();
    @(negedge clk);
    n_vec++;
    if (dut_out !== model_out()) begin
      n_err++; $display("FAIL reset_release got=%h want=%h", dut_out, model_out());
    end
    tick();
  endtask

  task automatic test_forward();
    set_idle();
    stage_rd = {5'd5, 5'd5}; stage_we = 2'b11; ex_rs = {5'd9, 5'd5};
    @(negedge clk);
    n_vec++;
    if (fwd_sel !== 4'b0001) begin
      n_err++; $display("FAIL fwd_mem_wins got=%b want=0001", fwd_sel);
    end
    stage_we = 2'b10;
    #1;
    n_vec++;
    if (fwd_sel !== 4'b0010) begin
      n_err++; $display("FAIL fwd_wb got=%b want=0010", fwd_sel);
    end
    stage_rd = {5'd0, 5'd0}; stage_we = 2'b11; ex_rs = {5'd0, 5'd0};
    #1;
    n_vec++;
    if (fwd_sel !== 4'b0000) begin
      n_err++; $display("FAIL fwd_x0 got=%b want=0000", fwd_sel);
    end
    stage_rd = {5'd9, 5'd3}; stage_we = 2'b11; ex_rs = {5'd9, 5'd3};
    #1;
    n_vec++;
    if (fwd_sel !== 4'b1001) begin
      n_err++; $display("FAIL fwd_both got=%b want=1001", fwd_sel);
    end
    tick();
  endtask

  task automatic test_load_use();
    set_idle();
    ex_is_load = 1'b1; ex_rd = 5'd7; id_rs = {5'd7, 5'd3}; id_rs_used = 2'b10;
    @(negedge clk);
    n_vec++;
    if ({stall_if, stall_id, bubble_ex, freeze} !== 4'b1110) begin
      n_err++; $display("FAIL load_use got=%b want=1110",
                        {stall_if, stall_id, bubble_ex, freeze});
    end
    tick();
    ex_is_load = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({stall_if, bubble_ex} !== 2'b00) begin
      n_err++; $display("FAIL load_use_clear got=%b want=00", {stall_if, bubble_ex});
    end
    tick();
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs = {5'd0, 5'd0}; id_rs_used = 2'b11;
    @(negedge clk);
    n_vec++;
    if ({stall_if, bubble_ex} !== 2'b00) begin
      n_err++; $display("FAIL load_use_x0 got=%b want=00", {stall_if, bubble_ex});
    end
    tick();
  endtask

  task automatic test_mem_wait();
    int frz_cycles;
    set_idle();
    do_reset();
    frz_cycles = 0;
    ex_is_load = 1'b1; ex_rd = 5'd4; id_rs = {5'd0, 5'd4}; id_rs_used = 2'b01;
    for (int c = 0; c < 3; c++) begin
      mem_req = 1'b1; dmem_ack = (c == 2);
      @(negedge clk);
      if (freeze) frz_cycles++;
      n_vec++;
      if ({freeze, bubble_ex, stall_if} !== 3'b101) begin
        n_err++; $display("FAIL mem_wait_c%0d got=%b want=101", c,
                          {freeze, bubble_ex, stall_if});
      end
      tick();
    end
    set_idle();
    @(negedge clk);
    n_vec++;
    if (freeze !== 1'b0 || frz_cycles != 3 || stall_count !== 16'd3) begin
      n_err++; $display("FAIL mem_wait_end freeze=%b cycles=%0d count=%0d want 0/3/3",
                        freeze, frz_cycles, stall_count);
    end
    tick();
  endtask

  task automatic test_timeout();
    set_idle();
    do_reset();
    mem_req = 1'b1;
    for (int c = 0; c < TO; c++) begin
      @(negedge clk);
      n_vec++;
      if ({freeze, bus_fault} !== 2'b10) begin
        n_err++; $display("FAIL timeout_wait_c%0d got=%b want=10", c, {freeze, bus_fault});
      end
      tick();
    end
    mem_req = 1'b0; dmem_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if ({bus_fault, freeze, stall_if, stall_id} !== 4'b1111) begin
        n_err++; $display("FAIL fault_sticky_c%0d got=%b want=1111", c,
                          {bus_fault, freeze, stall_if, stall_id});
      end
      tick();
    end
    set_idle();
    do_reset();
    @(negedge clk);
    n_vec++;
    if (dut_out !== 25'd0) begin
      n_err++; $display("FAIL fault_reset got=%h want=0", dut_out);
    end
    tick();
  endtask

  task automatic test_ack_at_limit();
    set_idle();
    do_reset();
    for (int c = 0; c < TO; c++) begin
      mem_req = 1'b1; dmem_ack = (c == TO - 1);
      @(negedge clk); tick();
    end
    set_idle();
    @(negedge clk);
    n_vec++;
    if ({bus_fault, freeze} !== 2'b00 || stall_count !== 16'(TO)) begin
      n_err++; $display("FAIL ack_at_limit fault/freeze=%b count=%0d want 00/%0d",
                        {bus_fault, freeze}, stall_count, TO);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      for (int s = 0; s < NS; s++) begin
        ex_rs[5*s +: 5] = 5'($urandom_range(0, 3));
        id_rs[5*s +: 5] = 5'($urandom_range(0, 3));
      end
      for (int k = 0; k < NF; k++) stage_rd[5*k +: 5] = 5'($urandom_range(0, 3));
      stage_we   = 2'($urandom);
      id_rs_used = 2'($urandom);
      ex_is_load = 1'($urandom);
      ex_rd      = 5'($urandom_range(0, 3));
      mem_req    = ($urandom_range(0, 3) == 0);
      dmem_ack   = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      n_vec++;
      if (dut_out !== model_out()) begin
        n_err++; $display("FAIL random_%0d got=%h want=%h", n, dut_out, model_out());
      end
      tick();
    end
  endtask

  task automatic test_saturate();
    set_idle();
    do_reset();
    ex_is_load = 1'b1; ex_rd = 5'd2; id_rs = {5'd2, 5'd0}; id_rs_used = 2'b10;
    repeat (70000) begin
      @(negedge clk); tick();
    end
    @(negedge clk);
    n_vec++;
    if (stall_count !== 16'hFFFF || dut_out !== model_out()) begin
      n_err++; $display("FAIL saturate got=%h want count ffff", stall_count);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (stall_count !== 16'hFFFF) begin
      n_err++; $display("FAIL saturate_hold got=%h want=ffff", stall_count);
    end
    tick();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_forward();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_ack_at_limit();
    test_random();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2: source operands checked per instruction.
REQ-002 SHALL have parameter NUM_FWD, default 2: forwarding stages; stage 0 is nearest (MEM), stage 1 is WB.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum data-memory wait cycles before fault; legal range 2..255.
REQ-004 SHALL derive localparam SELW = clog2(NUM_FWD+1), the width of one select field.
REQ-005 Ports, in this order:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- ex_rs  in  5*NUM_SRC  EX source registers; field i is [5i+4:5i].
- stage_rd  in  5*NUM_FWD  destination register per forwarding stage.
- stage_we  in  NUM_FWD  register-write enable per forwarding stage.
- id_rs  in  5*NUM_SRC  ID source registers.
- id_rs_used  in  NUM_SRC  per-source "operand is read" flag.
- ex_is_load  in  1  EX holds a load.
- ex_rd  in  5  EX destination register.
- mem_req  in  1  MEM stage issues a data-memory access this cycle.
- dmem_ack  in  1  data memory completes the access.
- fwd_sel  out  SELW*NUM_SRC  per-source select: 0 = register file, k+1 = stage k.
- stall_if  out  1  hold PC.
- stall_id  out  1  hold IF/ID register.
- bubble_ex  out  1  insert NOP into ID/EX.
- freeze  out  1  hold every pipeline register.
- bus_fault  out  1  sticky memory timeout flag.
- stall_count  out  16  saturating count of cycles with stall_if high.

Function
REQ-006 For source i, fwd_sel SHALL be k+1 for the lowest k where stage_we[k], stage_rd[k] != 0 and stage_rd[k] == ex_rs[i]; otherwise it SHALL be 0. This path is combinational, with zero latency.
REQ-007 Load-use hazard SHALL be defined as: ex_is_load, ex_rd != 0, and ex_rd == id_rs[i] for some i with id_rs_used[i].
REQ-008 The FSM SHALL have three states: RUN, MEM_WAIT and FAULT.
REQ-009 In RUN, if mem_req is high and dmem_ack is low, the FSM SHALL go to MEM_WAIT with wait_cnt = 1. Otherwise it SHALL stay in RUN.
REQ-010 In MEM_WAIT, on dmem_ack the FSM SHALL go to RUN. Otherwise, if wait_cnt == TIMEOUT-1 it SHALL go to FAULT. Otherwise wait_cnt SHALL increment.
REQ-011 FAULT SHALL be terminal until reset. In FAULT, bus_fault SHALL be 1 and freeze, stall_if and stall_id SHALL be held at 1.
REQ-012 freeze SHALL be 1 in MEM_WAIT, in FAULT, and in RUN while mem_req is high and dmem_ack is low (the wait is visible in the same cycle).
REQ-013 While freeze is 1, bubble_ex SHALL be 0 and stall_if = stall_id = 1, even if a load-use hazard is present.
REQ-014 When freeze is 0 and a load-use hazard exists, stall_if, stall_id and bubble_ex SHALL be 1 for exactly that cycle.
REQ-015 A load-use hazard SHALL clear naturally once the bubble advances the load; the block SHALL NOT hold any extra state for it.
REQ-016 stall_count SHALL increment every cycle stall_if is 1 and SHALL saturate at 0xFFFF.
REQ-017 Register x0 SHALL never forward and SHALL never cause a stall.
REQ-018 If dmem_ack arrives in the same cycle as the timeout compare, ack SHALL win and the FSM SHALL go to RUN.

Reset
REQ-019 When rst_n is low at a clk edge: state = RUN, wait_cnt = 0, stall_count = 0, bus_fault = 0.
REQ-020 While rst_n is low, fwd_sel, stall_if, stall_id, bubble_ex and freeze SHALL be driven 0.
REQ-021 Reset asserted in MEM_WAIT or FAULT SHALL return the block to RUN at the next edge, discarding the pending wait.

Structure
REQ-022 Package hazard_pkg SHALL hold the state encoding (RUN=0, MEM_WAIT=1, FAULT=2) and the FWD_RF=0 select constant.
REQ-023 Sub-module fwd_select SHALL compute the priority match for one source; the top level SHALL instantiate it NUM_SRC times via generate.

Verification
REQ-024 stage_rd = {WB:5, MEM:5}, both write-enabled, ex_rs[0] = 5 -> fwd_sel[0] = 1 (MEM wins). Disable MEM -> fwd_sel[0] = 2.
REQ-025 ex_is_load, ex_rd = 7, id_rs[1] = 7 with id_rs_used[1] -> stall_if, stall_id, bubble_ex = 1 for one cycle. Repeat with ex_rd = 0 -> no stall.
REQ-026 mem_req high, dmem_ack after 3 cycles -> freeze high for 3 cycles, bubble_ex = 0 throughout, RUN on the ack cycle, stall_count = 3.
REQ-027 TIMEOUT = 4, mem_req high, no ack -> FAULT after 4 freeze cycles, bus_fault = 1 sticky. rst_n low for one edge -> all outputs 0, state RUN.
REQ-028 Hold stall_if high for 70000 cycles -> stall_count saturates at 0xFFFF.
REQ-029 dmem_ack on the TIMEOUT-1 cycle -> RUN, bus_fault stays 0.
